// File: rtl/data_mem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding and
// requester identifiers, reused by the grant picker and the sequencer.
package data_mem_arbiter_pkg;

  // Sequencer states: one IDLE decision cycle, one strobe cycle, one done cycle.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } arb_state_e;

  // Requester identifiers as stored in the grant / last-grant registers.
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/data_mem_arbiter_rr_pick2.sv
// Two-way grant picker. Purely combinational: a lone requester always wins;
// on a tie either requester 0 wins (fixed priority) or the requester that
// was not served last wins (round-robin).
module rr_pick2
  import data_mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       fixed_prio,
  output logic       grant_valid,
  output logic       grant_id
);

  // Decode the request pair into a single grant.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = REQ0;
    case (req)
      2'b01: begin
        grant_valid = 1'b1;
        grant_id    = REQ0;
      end
      2'b10: begin
        grant_valid = 1'b1;
        grant_id    = REQ1;
      end
      2'b11: begin
        grant_valid = 1'b1;
        if (fixed_prio) begin
          grant_id = REQ0;
        end else begin
          grant_id = ~last_grant;
        end
      end
      default: begin
        grant_valid = 1'b0;
        grant_id    = REQ0;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-requester arbiter/sequencer in front of the shared data memory.
// One request is accepted at a time; the memory strobe is driven for exactly
// one cycle, read data is returned with a one-cycle done pulse. Every output
// comes straight from a register.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic [DATA_W-1:0] r0_rdata,
  output logic              r0_done,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              r1_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_MemWrite,
  output logic              mem_MemRead,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic FIXED_PRIO_L = (FIXED_PRIO != 0);

  arb_state_e        state_r,      state_nxt_s;
  logic              grant_r,      grant_nxt_s;
  logic              last_grant_r, last_grant_nxt_s;
  logic [ADDR_W-1:0] addr_r,       addr_nxt_s;
  logic [DATA_W-1:0] wdata_r,      wdata_nxt_s;
  logic              mem_we_r,     mem_we_nxt_s;
  logic              mem_re_r,     mem_re_nxt_s;
  logic [DATA_W-1:0] r0_rdata_r,   r0_rdata_nxt_s;
  logic [DATA_W-1:0] r1_rdata_r,   r1_rdata_nxt_s;
  logic              r0_done_r,    r0_done_nxt_s;
  logic              r1_done_r,    r1_done_nxt_s;
  logic              busy_r,       busy_nxt_s;

  logic              grant_valid_s;
  logic              grant_id_s;

  rr_pick2 u_pick (
    .req         ({r1_req, r0_req}),
    .last_grant  (last_grant_r),
    .fixed_prio  (FIXED_PRIO_L),
    .grant_valid (grant_valid_s),
    .grant_id    (grant_id_s)
  );

  // Next-state and next-output logic for the IDLE -> ACCESS -> DONE sequence.
  always_comb begin
    state_nxt_s      = state_r;
    grant_nxt_s      = grant_r;
    last_grant_nxt_s = last_grant_r;
    addr_nxt_s       = addr_r;
    wdata_nxt_s      = wdata_r;
    mem_we_nxt_s     = 1'b0;
    mem_re_nxt_s     = 1'b0;
    r0_rdata_nxt_s   = r0_rdata_r;
    r1_rdata_nxt_s   = r1_rdata_r;
    r0_done_nxt_s    = 1'b0;
    r1_done_nxt_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (grant_valid_s) begin
          grant_nxt_s = grant_id_s;
          if (grant_id_s == REQ1) begin
            addr_nxt_s   = r1_addr;
            wdata_nxt_s  = r1_wdata;
            mem_we_nxt_s = r1_we;
            mem_re_nxt_s = ~r1_we;
          end else begin
            addr_nxt_s   = r0_addr;
            wdata_nxt_s  = r0_wdata;
            mem_we_nxt_s = r0_we;
            mem_re_nxt_s = ~r0_we;
          end
          state_nxt_s = ST_ACCESS;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        // Memory read data is combinational, so it is valid in this cycle.
        if (grant_r == REQ1) begin
          r1_done_nxt_s = 1'b1;
          if (mem_re_r) begin
            r1_rdata_nxt_s = mem_rdata;
          end else begin
            r1_rdata_nxt_s = r1_rdata_r;
          end
        end else begin
          r0_done_nxt_s = 1'b1;
          if (mem_re_r) begin
            r0_rdata_nxt_s = mem_rdata;
          end else begin
            r0_rdata_nxt_s = r0_rdata_r;
          end
        end
        state_nxt_s = ST_DONE;
      end
      ST_DONE: begin
        // Requests are ignored here so the requester can retire its request.
        last_grant_nxt_s = grant_r;
        state_nxt_s      = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
    busy_nxt_s = (state_nxt_s != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      grant_r      <= REQ0;
      last_grant_r <= REQ1;
      addr_r       <= {ADDR_W{1'b0}};
      wdata_r      <= {DATA_W{1'b0}};
      mem_we_r     <= 1'b0;
      mem_re_r     <= 1'b0;
      r0_rdata_r   <= {DATA_W{1'b0}};
      r1_rdata_r   <= {DATA_W{1'b0}};
      r0_done_r    <= 1'b0;
      r1_done_r    <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      grant_r      <= grant_nxt_s;
      last_grant_r <= last_grant_nxt_s;
      addr_r       <= addr_nxt_s;
      wdata_r      <= wdata_nxt_s;
      mem_we_r     <= mem_we_nxt_s;
      mem_re_r     <= mem_re_nxt_s;
      r0_rdata_r   <= r0_rdata_nxt_s;
      r1_rdata_r   <= r1_rdata_nxt_s;
      r0_done_r    <= r0_done_nxt_s;
      r1_done_r    <= r1_done_nxt_s;
      busy_r       <= busy_nxt_s;
    end
  end

  assign mem_addr     = addr_r;
  assign mem_wdata    = wdata_r;
  assign mem_MemWrite = mem_we_r;
  assign mem_MemRead  = mem_re_r;
  assign r0_rdata     = r0_rdata_r;
  assign r1_rdata     = r1_rdata_r;
  assign r0_done      = r0_done_r;
  assign r1_done      = r1_done_r;
  assign busy         = busy_r;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: a round-robin instance backed by a behavioural
// memory and a transaction-level reference model, plus a fixed-priority
// instance backed by an address-derived read pattern.
module tb_data_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [31:0] FP_KEY = 32'h5A5A_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic          r0_req, r0_we, r0_done;
  logic [AW-1:0] r0_addr;
  logic [DW-1:0] r0_wdata, r0_rdata;
  logic          r1_req, r1_we, r1_done;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_wdata, r1_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_MemWrite, mem_MemRead, busy;

  logic          f0_req, f0_we, f0_done;
  logic [AW-1:0] f0_addr;
  logic [DW-1:0] f0_wdata, f0_rdata;
  logic          f1_req, f1_we, f1_done;
  logic [AW-1:0] f1_addr;
  logic [DW-1:0] f1_wdata, f1_rdata;
  logic [AW-1:0] f_mem_addr;
  logic [DW-1:0] f_mem_wdata, f_mem_rdata;
  logic          f_mem_MemWrite, f_mem_MemRead, f_busy;

  data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(0)) u_rr (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_rdata(r0_rdata), .r0_done(r0_done),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_rdata(r1_rdata), .r1_done(r1_done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_MemWrite(mem_MemWrite),
    .mem_MemRead(mem_MemRead), .mem_rdata(mem_rdata), .busy(busy)
  );

  data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1)) u_fp (
    .clk(clk), .rst(rst),
    .r0_req(f0_req), .r0_we(f0_we), .r0_addr(f0_addr), .r0_wdata(f0_wdata),
    .r0_rdata(f0_rdata), .r0_done(f0_done),
    .r1_req(f1_req), .r1_we(f1_we), .r1_addr(f1_addr), .r1_wdata(f1_wdata),
    .r1_rdata(f1_rdata), .r1_done(f1_done),
    .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata), .mem_MemWrite(f_mem_MemWrite),
    .mem_MemRead(f_mem_MemRead), .mem_rdata(f_mem_rdata), .busy(f_busy)
  );

  // Behavioural data memory for the round-robin instance (64 words, low address bits).
  logic [DW-1:0] mem [0:63];
  logic          pre_en;
  logic [5:0]    pre_addr;
  logic [DW-1:0] pre_data;

  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (mem_MemWrite) mem[mem_addr[5:0]] <= mem_wdata;
  end
  assign mem_rdata   = mem[mem_addr[5:0]];
  assign f_mem_rdata = f_mem_addr ^ FP_KEY;

  // Reference model state.
  logic [DW-1:0] ref_mem [0:63];
  logic          last_g;
  logic [DW-1:0] exp_rd0, exp_rd1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One transaction against the round-robin instance, starting from IDLE at a negedge.
  task automatic txn(input logic q0, input logic q1,
                     input logic we0, input logic [31:0] a0, input logic [31:0] d0,
                     input logic we1, input logic [31:0] a1, input logic [31:0] d1,
                     input logic drop);
    logic g, we;
    logic [31:0] a, d;
    r0_req = q0; r0_we = we0; r0_addr = a0; r0_wdata = d0;
    r1_req = q1; r1_we = we1; r1_addr = a1; r1_wdata = d1;
    @(posedge clk); @(negedge clk);
    if (!q0 && !q1) begin
      check("idle_strobes", 32'({mem_MemRead, mem_MemWrite}), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
    end else begin
      if (q0 && q1) g = ~last_g;
      else g = q1;
      we = g ? we1 : we0;
      a  = g ? a1 : a0;
      d  = g ? d1 : d0;
      check("acc_addr", mem_addr, a);
      check("acc_read", 32'(mem_MemRead), 32'(!we));
      check("acc_write", 32'(mem_MemWrite), 32'(we));
      if (we) check("acc_wdata", mem_wdata, d);
      check("acc_busy", 32'(busy), 32'd1);
      check("acc_no_done", 32'({r0_done, r1_done}), 32'd0);
      if (drop) begin
        if (g) r1_req = 1'b0;
        else r0_req = 1'b0;
      end
      @(posedge clk); @(negedge clk);
      if (we) ref_mem[a[5:0]] = d;
      else if (g) exp_rd1 = ref_mem[a[5:0]];
      else exp_rd0 = ref_mem[a[5:0]];
      last_g = g;
      check("done0", 32'(r0_done), 32'(!g));
      check("done1", 32'(r1_done), 32'(g));
      check("rdata0", r0_rdata, exp_rd0);
      check("rdata1", r1_rdata, exp_rd1);
      check("done_strobes", 32'({mem_MemRead, mem_MemWrite}), 32'd0);
      check("done_busy", 32'(busy), 32'd1);
      @(posedge clk); @(negedge clk);
      check("post_done", 32'({r0_done, r1_done}), 32'd0);
      check("post_strobes", 32'({mem_MemRead, mem_MemWrite}), 32'd0);
      check("post_busy", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    pre_en = 1'b0; pre_addr = 6'd0; pre_data = 32'd0;
    r0_req = 1'b0; r0_we = 1'b0; r0_addr = 32'd0; r0_wdata = 32'd0;
    r1_req = 1'b0; r1_we = 1'b0; r1_addr = 32'd0; r1_wdata = 32'd0;
    f0_req = 1'b0; f0_we = 1'b0; f0_addr = 32'd0; f0_wdata = 32'd0;
    f1_req = 1'b0; f1_we = 1'b0; f1_addr = 32'd0; f1_wdata = 32'd0;
    last_g = 1'b1; exp_rd0 = 32'd0; exp_rd1 = 32'd0;

    // Preload memory while held in reset; mem[1] = 69.
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      pre_en = 1'b1;
      pre_addr = 6'(i);
      pre_data = (i == 1) ? 32'd69 : $urandom;
      ref_mem[i] = pre_data;
    end
    @(negedge clk);
    pre_en = 1'b0;

    // Reset state.
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_strobes", 32'({mem_MemRead, mem_MemWrite}), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_done", 32'({r0_done, r1_done}), 32'd0);
    check("rst_rdata0", r0_rdata, 32'd0);
    check("rst_rdata1", r1_rdata, 32'd0);
    check("rst_fp_busy", 32'(f_busy), 32'd0);
    rst = 1'b0;

    // Round-robin contention from reset: r0, r1, r0, r1.
    for (int i = 0; i < 4; i++) begin
      txn(1'b1, 1'b1, 1'b0, 32'd8, 32'd0, 1'b0, 32'd12, 32'd0, 1'b0);
      check("rr_order", 32'(last_g), 32'(i % 2));
    end

    // Single read of address 1.
    txn(1'b1, 1'b0, 1'b0, 32'd1, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
    check("single_read_69", r0_rdata, 32'd69);

    // Write then read back through requester 1.
    txn(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 32'd4, 32'hDEAD_BEEF, 1'b0);
    txn(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 32'd4, 32'd0, 1'b0);
    check("readback_deadbeef", r1_rdata, 32'hDEAD_BEEF);

    // Request dropped during ACCESS still completes; no second access follows.
    txn(1'b1, 1'b0, 1'b0, 32'd1, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1);
    txn(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);

    // Reset during the ACCESS cycle of an r0 write (last grant was r0 here).
    r0_req = 1'b1; r0_we = 1'b1; r0_addr = 32'd20; r0_wdata = 32'h1234_5678;
    r1_req = 1'b0;
    @(posedge clk); @(negedge clk);
    check("rst_mid_write", 32'(mem_MemWrite), 32'd1);
    rst = 1'b1;
    r0_req = 1'b0;
    @(posedge clk); @(negedge clk);
    ref_mem[20] = 32'h1234_5678;
    exp_rd0 = 32'd0; exp_rd1 = 32'd0; last_g = 1'b1;
    check("rst_mid_done", 32'({r0_done, r1_done}), 32'd0);
    check("rst_mid_strobes", 32'({mem_MemRead, mem_MemWrite}), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    txn(1'b1, 1'b1, 1'b0, 32'd20, 32'd0, 1'b0, 32'd12, 32'd0, 1'b0);
    check("rst_mid_tie_r0", 32'(last_g), 32'd0);

    // Randomised traffic against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic q0, q1, w0, w1, dr;
      logic [31:0] a0, a1, d0, d1;
      q0 = 1'($urandom_range(0, 1));
      q1 = 1'($urandom_range(0, 1));
      w0 = 1'($urandom_range(0, 1));
      w1 = 1'($urandom_range(0, 1));
      dr = ($urandom_range(0, 3) == 0);
      a0 = $urandom; a1 = $urandom; d0 = $urandom; d1 = $urandom;
      txn(q0, q1, w0, a0, d0, w1, a1, d1, dr);
    end
    r0_req = 1'b0; r1_req = 1'b0;

    // Fixed priority: r0 wins every tie until its request drops.
    f0_req = 1'b1; f0_we = 1'b0; f0_addr = 32'd8;
    f1_req = 1'b1; f1_we = 1'b0; f1_addr = 32'd12;
    for (int k = 0; k < 4; k++) begin
      logic fg;
      logic [31:0] fa;
      fg = (k == 3);
      fa = fg ? 32'd12 : 32'd8;
      @(posedge clk); @(negedge clk);
      check("fp_addr", f_mem_addr, fa);
      check("fp_read", 32'(f_mem_MemRead), 32'd1);
      @(posedge clk); @(negedge clk);
      check("fp_done0", 32'(f0_done), 32'(!fg));
      check("fp_done1", 32'(f1_done), 32'(fg));
      if (fg) check("fp_rdata1", f1_rdata, fa ^ FP_KEY);
      else check("fp_rdata0", f0_rdata, fa ^ FP_KEY);
      if (k == 2) f0_req = 1'b0;
      if (k == 3) f1_req = 1'b0;
      @(posedge clk); @(negedge clk);
    end
    @(posedge clk); @(negedge clk);
    check("fp_idle", 32'({f_busy, f_mem_MemRead, f_mem_MemWrite}), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
